snescmd_wr_arb: RTL and testbench
=================================

SNESCMD_WR_ARB -- requirements
Module: snescmd_wr_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd42000 (0.5 ms at 84 MHz), the mailbox lockout timeout in clk cycles.
REQ-002 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port SNES_cycle_start  in  1  one-clk pulse at SNES bus cycle start.
REQ-005 SHALL have port snescmd_enable  in  1  SNES currently addressing snescmd RAM (RAM write blocked).
REQ-006 SHALL have port snes_rd_cmd0  in  1  one-clk pulse: SNES read of snescmd offset 0.
REQ-007 SHALL have ports snescmd_we_cheat / snescmd_addr_cheat / snescmd_data_cheat  in  1/9/8  cheat write request (valid when we high).
REQ-008 SHALL have port snescmd_rdy  out  1  cheat source may issue; a write is accepted iff we & rdy.
REQ-009 SHALL have ports mcu_we / mcu_addr / mcu_data  in  1/9/8  MCU write request pulse.
REQ-010 SHALL have port mcu_full  out  1  MCU FIFO full; requests dropped while high.
REQ-011 SHALL have ports ram_we / ram_addr / ram_data  out  1/9/8  snescmd RAM write port.
REQ-012 SHALL have ports dbg_cheat_cnt / dbg_mcu_cnt / dbg_drop_cnt  out  8/8/8  statistics.

Function
REQ-013 SHALL buffer MCU requests in a 4-entry FIFO (2-bit pointers wrapping 3->0, 3-bit occupancy); mcu_full = occupancy==4.
REQ-014 SHALL drop an MCU request arriving while full (same-cycle pop does not make room) and increment dbg_drop_cnt.
REQ-015 SHALL hold one accepted cheat request in a single holding register (cheat_pend).
REQ-016 SHALL assert snescmd_rdy = ~cheat_pend & state!=LOCK & ~RST-derived state.
REQ-017 SHALL implement states IDLE, WRITE, LOCK.
REQ-018 IDLE: if ~snescmd_enable and (cheat_pend or FIFO non-empty) -> WRITE; cheat_pend has priority over FIFO.
REQ-019 WRITE: ram_we=1 for exactly one cycle with the selected entry; the entry is consumed (cheat_pend cleared or FIFO popped) that cycle.
REQ-020 WRITE exit: cheat write with addr 0 -> LOCK (timer loaded with TIMEOUT); otherwise -> IDLE.
REQ-021 LOCK: cheat writes blocked (snescmd_rdy=0); MCU writes still issued one per cycle while ~snescmd_enable, ram_we asserted combinationally from the FIFO head.
REQ-022 LOCK exit to IDLE on snes_rd_cmd0 or timer reaching 0; timer decrements every clk, saturates at 0.
REQ-023 snes_rd_cmd0 and timer expiry in the same cycle SHALL be one exit, no double action.
REQ-024 SHALL never assert ram_we while snescmd_enable=1; a pending write waits, minimum latency accept->ram_we = 1 cycle.
REQ-025 SHALL accept a cheat request and an MCU push in the same cycle without loss.
REQ-026 ram_addr/ram_data SHALL be 0 when ram_we=0.
REQ-027 dbg_cheat_cnt / dbg_mcu_cnt SHALL count issued RAM writes per source, wrapping at 255->0.

Reset
REQ-028 On RST: state=IDLE, FIFO empty, cheat_pend=0, timer=0, counters=0.
REQ-029 Reset outputs: snescmd_rdy=0 while RST high, 1 first cycle after; mcu_full=0; ram_we=0; ram_addr=0; ram_data=0; dbg_*=0.
REQ-030 RST mid-WRITE or mid-LOCK SHALL discard all buffered requests; no ram_we after RST release until a new request.

Configuration
REQ-031 Macro SNESCMD_ARB_STATS_EN: defined -> REQ-014/REQ-027 counters implemented; undefined -> counter logic absent, dbg_* tied to 0, all other behaviour identical.

Verification
REQ-032 Cheat we, addr 0x000, data 0x81, snescmd_enable=0 -> ram_we 1 cycle later with 0x000/0x81, snescmd_rdy low until snes_rd_cmd0.
REQ-033 LOCK entered, no snes_rd_cmd0 -> snescmd_rdy returns high exactly TIMEOUT+1 cycles after the WRITE cycle.
REQ-034 Five MCU pushes back-to-back with snescmd_enable=1 -> mcu_full after 4th, 5th dropped, dbg_drop_cnt=1; release enable -> 4 writes in order.
REQ-035 Cheat and MCU request same cycle -> cheat written first, MCU next cycle, none lost.
REQ-036 RST asserted during LOCK with 2 FIFO entries -> all outputs at reset values, no ram_we after release.

Source files
------------

// File: rtl/snescmd_wr_arb.sv
// snescmd RAM write arbiter: one cheat holding register plus a 4-deep MCU FIFO.
// The cheat source has priority, and a cheat write to offset 0 locks out further cheat writes.
// Latency is 1 cycle from accept to ram_we, with one write issued per cycle while the SNES is not on snescmd.
// Backpressure: snescmd_rdy gates cheat requests. MCU requests that arrive while mcu_full is high are dropped.
// The optional statistics counters are built only when SNESCMD_ARB_STATS_EN is defined.
module snescmd_wr_arb #(
  parameter logic [15:0] TIMEOUT = 16'd42000
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       SNES_cycle_start,
  input  logic       snescmd_enable,
  input  logic       snes_rd_cmd0,
  input  logic       snescmd_we_cheat,
  input  logic [8:0] snescmd_addr_cheat,
  input  logic [7:0] snescmd_data_cheat,
  output logic       snescmd_rdy,
  input  logic       mcu_we,
  input  logic [8:0] mcu_addr,
  input  logic [7:0] mcu_data,
  output logic       mcu_full,
  output logic       ram_we,
  output logic [8:0] ram_addr,
  output logic [7:0] ram_data,
  output logic [7:0] dbg_cheat_cnt,
  output logic [7:0] dbg_mcu_cnt,
  output logic [7:0] dbg_drop_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, LOCK = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [16:0] fifo_mem_q [4];
  logic [16:0] fifo_mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]  fifo_cnt_q, fifo_cnt_d;
  logic        cheat_pend_q, cheat_pend_d;
  logic [8:0]  cheat_addr_q, cheat_addr_d;
  logic [7:0]  cheat_data_q, cheat_data_d;
  logic [15:0] timer_q, timer_d;

  logic        fifo_empty, cheat_issue, mcu_issue, cheat_acc, mcu_push;
  logic [16:0] fifo_head;

  // Bus cycle timing is not needed: snescmd_enable already qualifies every cycle.
  logic unused_cycle_start;
  assign unused_cycle_start = SNES_cycle_start;

  // Pick this cycle's RAM write and drive the handshake outputs.
  always_comb begin
    fifo_empty  = (fifo_cnt_q == 3'd0);
    fifo_head   = fifo_mem_q[rd_ptr_q];
    cheat_issue = 1'b0;
    mcu_issue   = 1'b0;
    if (!snescmd_enable) begin
      if (state_q == WRITE) begin
        cheat_issue = cheat_pend_q;
        mcu_issue   = ~cheat_pend_q & ~fifo_empty;
      end else if (state_q == LOCK) begin
        mcu_issue = ~fifo_empty;
      end
    end
    ram_we   = cheat_issue | mcu_issue;
    ram_addr = 9'd0;
    ram_data = 8'd0;
    if (cheat_issue) begin
      ram_addr = cheat_addr_q;
      ram_data = cheat_data_q;
    end else if (mcu_issue) begin
      ram_addr = fifo_head[16:8];
      ram_data = fifo_head[7:0];
    end
    snescmd_rdy = ~RST & ~cheat_pend_q & (state_q != LOCK);
    mcu_full    = (fifo_cnt_q == 3'd4);
    cheat_acc   = snescmd_we_cheat & snescmd_rdy;
    // The occupancy check comes before this cycle's pop, so a same-cycle pop does not make room.
    mcu_push    = mcu_we & ~mcu_full;
  end

  // Next state for the buffers, the lockout timer and the FSM.
  // WRITE is entered as soon as work will be waiting next cycle, which gives a 1-cycle accept-to-write latency.
  // The FSM stays in WRITE while entries remain, so writes go out back to back.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (mcu_push) begin
      fifo_mem_d[wr_ptr_q] = {mcu_addr, mcu_data};
      wr_ptr_d             = wr_ptr_q + 2'd1;
    end
    if (mcu_issue) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    fifo_cnt_d = fifo_cnt_q + {2'b00, mcu_push} - {2'b00, mcu_issue};

    cheat_pend_d = cheat_pend_q & ~cheat_issue;
    cheat_addr_d = cheat_addr_q;
    cheat_data_d = cheat_data_q;
    if (cheat_acc) begin
      cheat_pend_d = 1'b1;
      cheat_addr_d = snescmd_addr_cheat;
      cheat_data_d = snescmd_data_cheat;
    end

    timer_d = (timer_q != 16'd0) ? timer_q - 16'd1 : 16'd0;
    state_d = state_q;
    case (state_q)
      LOCK: begin
        // A read of offset 0 and timer expiry in the same cycle are treated as a single exit.
        if (snes_rd_cmd0 || timer_q <= 16'd1) state_d = IDLE;
      end
      default: begin
        if (cheat_issue && cheat_addr_q == 9'd0) begin
          state_d = LOCK;
          timer_d = TIMEOUT;
        end else if (cheat_pend_d || fifo_cnt_d != 3'd0) begin
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Control state. Reset discards every buffered request.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      fifo_cnt_q   <= 3'd0;
      cheat_pend_q <= 1'b0;
      cheat_addr_q <= 9'd0;
      cheat_data_q <= 8'd0;
      timer_q      <= 16'd0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      cheat_pend_q <= cheat_pend_d;
      cheat_addr_q <= cheat_addr_d;
      cheat_data_q <= cheat_data_d;
      timer_q      <= timer_d;
    end
  end

  // FIFO storage. No reset is needed because the occupancy count decides whether an entry is valid.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

`ifdef SNESCMD_ARB_STATS_EN
  logic [7:0] cheat_cnt_q, cheat_cnt_d, mcu_cnt_q, mcu_cnt_d, drop_cnt_q, drop_cnt_d;
  logic       mcu_drop;

  // Per-source issued-write counters and an MCU drop counter. All three wrap at 255.
  always_comb begin
    mcu_drop    = mcu_we & mcu_full;
    cheat_cnt_d = cheat_cnt_q + {7'd0, cheat_issue};
    mcu_cnt_d   = mcu_cnt_q + {7'd0, mcu_issue};
    drop_cnt_d  = drop_cnt_q + {7'd0, mcu_drop};
  end

  // Counter registers.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cheat_cnt_q <= 8'd0;
      mcu_cnt_q   <= 8'd0;
      drop_cnt_q  <= 8'd0;
    end else begin
      cheat_cnt_q <= cheat_cnt_d;
      mcu_cnt_q   <= mcu_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign dbg_cheat_cnt = cheat_cnt_q;
  assign dbg_mcu_cnt   = mcu_cnt_q;
  assign dbg_drop_cnt  = drop_cnt_q;
`else
  assign dbg_cheat_cnt = 8'd0;
  assign dbg_mcu_cnt   = 8'd0;
  assign dbg_drop_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_snescmd_wr_arb.sv
// Bench for snescmd_wr_arb: a queue-based reference model plus directed scenarios and random traffic.
// The model steps on every rising edge, and the outputs are compared on every falling edge.
// Cheat/MCU requests, snescmd_enable, read-of-offset-0 and reset are all randomized.
module tb_snescmd_wr_arb;
  localparam logic [15:0] TO = 16'd20;
`ifdef SNESCMD_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int P_IDLE = 0, P_WR = 1, P_LK = 2;

  logic       clk = 1'b0;
  logic       RST;
  logic       SNES_cycle_start, snescmd_enable, snes_rd_cmd0;
  logic       snescmd_we_cheat;
  logic [8:0] snescmd_addr_cheat;
  logic [7:0] snescmd_data_cheat;
  logic       snescmd_rdy;
  logic       mcu_we;
  logic [8:0] mcu_addr;
  logic [7:0] mcu_data;
  logic       mcu_full, ram_we;
  logic [8:0] ram_addr;
  logic [7:0] ram_data;
  logic [7:0] dbg_cheat_cnt, dbg_mcu_cnt, dbg_drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  snescmd_wr_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .RST(RST), .SNES_cycle_start(SNES_cycle_start),
    .snescmd_enable(snescmd_enable), .snes_rd_cmd0(snes_rd_cmd0),
    .snescmd_we_cheat(snescmd_we_cheat), .snescmd_addr_cheat(snescmd_addr_cheat),
    .snescmd_data_cheat(snescmd_data_cheat), .snescmd_rdy(snescmd_rdy),
    .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_data(mcu_data), .mcu_full(mcu_full),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .dbg_cheat_cnt(dbg_cheat_cnt), .dbg_mcu_cnt(dbg_mcu_cnt), .dbg_drop_cnt(dbg_drop_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, one pending cheat, a phase and a countdown.
  logic [16:0] m_q[$];
  bit          m_pend;
  logic [16:0] m_pv;
  int          m_phase, m_timer, m_cc, m_mc, m_dc;

  // Which source writes this cycle: 0 = none, 1 = cheat, 2 = MCU FIFO head.
  function automatic int m_kind();
    if (snescmd_enable) return 0;
    if (m_phase == P_WR && m_pend) return 1;
    if ((m_phase == P_WR || m_phase == P_LK) && m_q.size() > 0) return 2;
    return 0;
  endfunction

  function automatic bit m_rdy();
    return !RST && !m_pend && (m_phase != P_LK);
  endfunction

  always @(posedge clk or posedge RST) begin
    if (RST) begin
      m_q.delete();
      m_pend = 0; m_pv = '0; m_phase = P_IDLE; m_timer = 0;
      m_cc = 0; m_mc = 0; m_dc = 0;
    end else begin
      int k, sz;
      bit rdy, lock_now;
      k = m_kind(); rdy = m_rdy(); sz = m_q.size(); lock_now = 0;
      if (k == 1) begin
        m_pend = 0; m_cc++;
        if (m_pv[16:8] == 9'd0) lock_now = 1;
      end
      if (k == 2) begin
        void'(m_q.pop_front());
        m_mc++;
      end
      if (mcu_we) begin
        if (sz == 4) m_dc++;
        else m_q.push_back({mcu_addr, mcu_data});
      end
      if (snescmd_we_cheat && rdy) begin
        m_pend = 1; m_pv = {snescmd_addr_cheat, snescmd_data_cheat};
      end
      if (m_phase == P_LK) begin
        if (snes_rd_cmd0 || m_timer <= 1) m_phase = P_IDLE;
        m_timer = (m_timer > 0) ? m_timer - 1 : 0;
      end else if (lock_now) begin
        m_phase = P_LK; m_timer = int'(TO);
      end else begin
        m_phase = (m_pend || m_q.size() > 0) ? P_WR : P_IDLE;
        m_timer = (m_timer > 0) ? m_timer - 1 : 0;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (RST) begin
      chk("rst_rdy", 32'(snescmd_rdy), 32'd0);
      chk("rst_full", 32'(mcu_full), 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);
      chk("rst_data", 32'(ram_data), 32'd0);
      chk("rst_dbg", {8'd0, dbg_cheat_cnt, dbg_mcu_cnt, dbg_drop_cnt}, 32'd0);
    end else begin
      int k;
      logic [16:0] e;
      k = m_kind();
      e = (k == 1) ? m_pv : (k == 2) ? m_q[0] : 17'd0;
      chk("ram_we", 32'(ram_we), 32'(k != 0));
      chk("ram_addr", 32'(ram_addr), 32'(e[16:8]));
      chk("ram_data", 32'(ram_data), 32'(e[7:0]));
      chk("snescmd_rdy", 32'(snescmd_rdy), 32'(m_rdy()));
      chk("mcu_full", 32'(mcu_full), 32'(m_q.size() == 4));
      chk("dbg_cheat", 32'(dbg_cheat_cnt), STATS ? 32'(m_cc[7:0]) : 32'd0);
      chk("dbg_mcu", 32'(dbg_mcu_cnt), STATS ? 32'(m_mc[7:0]) : 32'd0);
      chk("dbg_drop", 32'(dbg_drop_cnt), STATS ? 32'(m_dc[7:0]) : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    SNES_cycle_start = 0; snescmd_enable = 0; snes_rd_cmd0 = 0;
    snescmd_we_cheat = 0; snescmd_addr_cheat = '0; snescmd_data_cheat = '0;
    mcu_we = 0; mcu_addr = '0; mcu_data = '0;
  endtask

  task automatic do_reset();
    RST = 1; clear_in();
    repeat (2) tick();
    RST = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit done;
    RST = 1; clear_in();
    @(negedge clk);
    chk("reset_rdy_low", 32'(snescmd_rdy), 32'd0);
    chk("reset_ram_we", 32'(ram_we), 32'd0);
    tick(); tick();
    RST = 0;
    @(negedge clk);
    chk("rdy_after_release", 32'(snescmd_rdy), 32'd1);

    // Cheat write to offset 0: written next cycle, then locked until the SNES reads offset 0.
    tick();
    snescmd_we_cheat = 1; snescmd_addr_cheat = 9'h000; snescmd_data_cheat = 8'h81;
    @(negedge clk);
    chk("cheat_rdy_at_accept", 32'(snescmd_rdy), 32'd1);
    tick();
    snescmd_we_cheat = 0;
    @(negedge clk);
    chk("cheat_we", 32'(ram_we), 32'd1);
    chk("cheat_addr", 32'(ram_addr), 32'h000);
    chk("cheat_data", 32'(ram_data), 32'h81);
    chk("cheat_rdy_low", 32'(snescmd_rdy), 32'd0);
    repeat (5) tick();
    @(negedge clk);
    chk("lock_holds", 32'(snescmd_rdy), 32'd0);
    tick();
    snes_rd_cmd0 = 1;
    tick();
    snes_rd_cmd0 = 0;
    @(negedge clk);
    chk("unlock_by_rd0", 32'(snescmd_rdy), 32'd1);

    // Lockout timeout with no read of offset 0.
    tick();
    snescmd_we_cheat = 1; snescmd_addr_cheat = 9'h000; snescmd_data_cheat = 8'h05;
    tick();
    snescmd_we_cheat = 0;
    @(negedge clk);
    chk("to_write_cycle", 32'(ram_we), 32'd1);
    n = 0; done = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (snescmd_rdy) done = 1;
    end
    chk("timeout_cycles", 32'(n), 32'(TO) + 32'd1);

    // The MCU FIFO fills up while snescmd is busy, then drains in order.
    do_reset();
    tick();
    snescmd_enable = 1;
    for (int i = 0; i < 5; i++) begin
      mcu_we = 1; mcu_addr = 9'h100 + 9'(i); mcu_data = 8'h10 + 8'(i);
      @(negedge clk);
      if (i == 3) chk("not_full_at_4th", 32'(mcu_full), 32'd0);
      if (i == 4) chk("full_at_5th", 32'(mcu_full), 32'd1);
      tick();
    end
    mcu_we = 0;
    @(negedge clk);
    chk("drop_cnt", 32'(dbg_drop_cnt), STATS ? 32'd1 : 32'd0);
    chk("no_we_when_enabled", 32'(ram_we), 32'd0);
    tick();
    snescmd_enable = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_we", 32'(ram_we), 32'd1);
      chk("drain_addr", 32'(ram_addr), 32'h100 + 32'(i));
      chk("drain_data", 32'(ram_data), 32'h10 + 32'(i));
      tick();
    end
    @(negedge clk);
    chk("drained_idle", 32'(ram_we), 32'd0);
    chk("drained_not_full", 32'(mcu_full), 32'd0);

    // Cheat and MCU requests in the same cycle.
    do_reset();
    tick();
    snescmd_we_cheat = 1; snescmd_addr_cheat = 9'h055; snescmd_data_cheat = 8'hAA;
    mcu_we = 1; mcu_addr = 9'h1AB; mcu_data = 8'h33;
    tick();
    clear_in();
    @(negedge clk);
    chk("both_first_addr", 32'(ram_addr), 32'h055);
    chk("both_first_data", 32'(ram_data), 32'hAA);
    tick();
    @(negedge clk);
    chk("both_second_we", 32'(ram_we), 32'd1);
    chk("both_second_addr", 32'(ram_addr), 32'h1AB);
    chk("both_second_data", 32'(ram_data), 32'h33);
    tick();
    @(negedge clk);
    chk("both_done", 32'(ram_we), 32'd0);

    // Reset during LOCK with two MCU entries buffered.
    do_reset();
    tick();
    snescmd_we_cheat = 1; snescmd_addr_cheat = 9'h000; snescmd_data_cheat = 8'h01;
    tick();
    clear_in();
    tick();
    snescmd_enable = 1; mcu_we = 1; mcu_addr = 9'h012; mcu_data = 8'h34;
    tick();
    mcu_addr = 9'h013;
    tick();
    mcu_we = 0;
    @(negedge clk);
    chk("lock_before_rst", 32'(snescmd_rdy), 32'd0);
    tick();
    RST = 1;
    #1;
    chk("midrst_rdy", 32'(snescmd_rdy), 32'd0);
    chk("midrst_we", 32'(ram_we), 32'd0);
    chk("midrst_full", 32'(mcu_full), 32'd0);
    chk("midrst_addr_data", {15'd0, ram_addr, ram_data}, 32'd0);
    chk("midrst_dbg", {8'd0, dbg_cheat_cnt, dbg_mcu_cnt, dbg_drop_cnt}, 32'd0);
    tick(); tick();
    RST = 0; snescmd_enable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_we_after_rst", 32'(ram_we), 32'd0);
      tick();
    end

    // Random traffic checked by the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      RST                = ($urandom_range(0, 499) == 0);
      SNES_cycle_start   = ($urandom_range(0, 5) == 0);
      snescmd_enable     = ($urandom_range(0, 99) < 30);
      snes_rd_cmd0       = ($urandom_range(0, 99) < 5);
      snescmd_we_cheat   = ($urandom_range(0, 99) < 40);
      snescmd_addr_cheat = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom);
      snescmd_data_cheat = 8'($urandom);
      mcu_we             = ($urandom_range(0, 99) < 40);
      mcu_addr           = 9'($urandom);
      mcu_data           = 8'($urandom);
    end
    tick();
    RST = 0; clear_in();
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
